// File: rtl/ts_packet_arbiter.sv
// ts_packet_arbiter: N-channel transport-stream packet multiplexer.
// Grants whole PKT_LEN-byte packets by round-robin, fixed priority or single
// source under a channel mask, with optional null-packet fill and byte pacing.
module ts_packet_arbiter #(
   parameter int N_CH    = 4,
   parameter int CH_W    = 2,
   parameter int PKT_LEN = 188,
   parameter int GAP     = 0
) (
   input  logic                SYS_CLK,
   input  logic                RST,
   input  logic [N_CH-1:0]     GOT_FULL_PACKET,
   input  logic [8*N_CH-1:0]   DATA_IN_BUS,
   output logic [N_CH-1:0]     RD_REQ,
   input  logic [1:0]          MODE,
   input  logic [CH_W-1:0]     SEL,
   input  logic [N_CH-1:0]     CH_MASK,
   input  logic                NULL_EN,
   output logic [7:0]          DATA_OUT,
   output logic                D_VALID_OUT,
   output logic                P_SYNC_OUT,
   output logic [CH_W-1:0]     ACTIVE_CH,
   output logic                NULL_PKT,
   output logic                SYNC_ERR,
   output logic                PKT_DONE
);

   localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [BW-1:0] LAST_IDX = BW'(PKT_LEN - 1);
   localparam logic [GW-1:0] GAP_LD   = GW'(GAP);

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_NULL} state_t;

   state_t           state;
   logic [CH_W-1:0]  ch_q;
   logic [CH_W-1:0]  ptr_q;
   logic [BW-1:0]    byte_cnt;
   logic [GW-1:0]    gap_cnt;
   logic             vld_q;
   logic             first_q;
   logic             last_q;
   logic             null_q;
   logic [7:0]       nbyte_q;
   logic [7:0]       hold_q;

   logic [N_CH-1:0]  elig;
   logic             grant_any;
   logic [CH_W-1:0]  grant_ch;
   logic [7:0]       ch_byte;

   function automatic logic [N_CH-1:0] ch_onehot(input logic [CH_W-1:0] c);
      ch_onehot = '0;
      for (int unsigned i = 0; i < N_CH; i++)
         if (c == CH_W'(i)) ch_onehot[i] = 1'b1;
   endfunction

   function automatic logic [7:0] null_byte(input logic [BW-1:0] idx);
      if (idx == BW'(0))      null_byte = 8'h47;
      else if (idx == BW'(1)) null_byte = 8'h1F;
      else if (idx == BW'(3)) null_byte = 8'h10;
      else                    null_byte = 8'hFF;
   endfunction

   // Eligible channels for the current mode; SEL beyond N_CH matches nothing.
   always_comb begin
      elig = '0;
      case (MODE)
         2'd0, 2'd1: elig = GOT_FULL_PACKET & CH_MASK;
         2'd2: begin
            for (int unsigned i = 0; i < N_CH; i++)
               if (SEL == CH_W'(i)) elig[i] = GOT_FULL_PACKET[i] & CH_MASK[i];
         end
         default: elig = '0;
      endcase
   end

   // Grant pick: round-robin searches above ptr first, then wraps to 0..ptr;
   // the other modes take the lowest eligible index.
   always_comb begin
      grant_any = 1'b0;
      grant_ch  = '0;
      if (MODE == 2'd0) begin
         for (int unsigned i = 0; i < N_CH; i++)
            if (!grant_any && elig[i] && (CH_W'(i) > ptr_q)) begin
               grant_any = 1'b1;
               grant_ch  = CH_W'(i);
            end
         for (int unsigned i = 0; i < N_CH; i++)
            if (!grant_any && elig[i] && (CH_W'(i) <= ptr_q)) begin
               grant_any = 1'b1;
               grant_ch  = CH_W'(i);
            end
      end else begin
         for (int unsigned i = 0; i < N_CH; i++)
            if (!grant_any && elig[i]) begin
               grant_any = 1'b1;
               grant_ch  = CH_W'(i);
            end
      end
   end

   // Byte of the active channel as presented by its FIFO.
   always_comb begin
      ch_byte = '0;
      for (int unsigned i = 0; i < N_CH; i++)
         if (ch_q == CH_W'(i)) ch_byte = DATA_IN_BUS[8*i +: 8];
   end

   // FIFO data appears the cycle after RD_REQ, which is the same cycle the
   // byte must be on DATA_OUT, so the byte is steered from the bus while
   // vld_q is set; hold_q keeps the last byte between slots.
   assign DATA_OUT    = vld_q ? (null_q ? nbyte_q : ch_byte) : hold_q;
   assign SYNC_ERR    = vld_q & first_q & ~null_q & (ch_byte != 8'h47);
   assign D_VALID_OUT = vld_q;
   assign P_SYNC_OUT  = first_q;
   assign PKT_DONE    = last_q;
   assign NULL_PKT    = null_q;
   assign ACTIVE_CH   = ch_q;

   // Packet FSM: grant in IDLE, then one byte slot every GAP+1 cycles.
   always_ff @(posedge SYS_CLK) begin
      if (RST) begin
         state    <= ST_IDLE;
         ch_q     <= '0;
         ptr_q    <= CH_W'(N_CH - 1);
         byte_cnt <= '0;
         gap_cnt  <= '0;
         RD_REQ   <= '0;
         vld_q    <= 1'b0;
         first_q  <= 1'b0;
         last_q   <= 1'b0;
         null_q   <= 1'b0;
         nbyte_q  <= '0;
         hold_q   <= '0;
      end else begin
         hold_q  <= DATA_OUT;
         vld_q   <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         null_q  <= 1'b0;
         case (state)
            ST_IDLE: begin
               byte_cnt <= '0;
               gap_cnt  <= '0;
               RD_REQ   <= '0;
               if (grant_any) begin
                  state  <= ST_READ;
                  ch_q   <= grant_ch;
                  RD_REQ <= ch_onehot(grant_ch);
                  if (MODE == 2'd0) ptr_q <= grant_ch;
               end else if (NULL_EN) begin
                  state <= ST_NULL;
               end
            end
            ST_READ, ST_NULL: begin
               if (gap_cnt == '0) begin
                  vld_q   <= 1'b1;
                  first_q <= (byte_cnt == '0);
                  last_q  <= (byte_cnt == LAST_IDX);
                  null_q  <= (state == ST_NULL);
                  nbyte_q <= null_byte(byte_cnt);
                  if (byte_cnt == LAST_IDX) begin
                     state  <= ST_IDLE;
                     RD_REQ <= '0;
                  end else begin
                     byte_cnt <= byte_cnt + BW'(1);
                     gap_cnt  <= GAP_LD;
                     RD_REQ   <= (GAP == 0 && state == ST_READ) ? ch_onehot(ch_q) : '0;
                  end
               end else begin
                  gap_cnt <= gap_cnt - GW'(1);
                  RD_REQ  <= (gap_cnt == GW'(1) && state == ST_READ) ? ch_onehot(ch_q) : '0;
               end
            end
            default: begin
               state  <= ST_IDLE;
               RD_REQ <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ts_packet_arbiter.sv
// Bench for ts_packet_arbiter: table of per-packet grant vectors with a byte
// scoreboard, plus reset-abort and GAP=2 pacing sequences.
module tb_ts_packet_arbiter;

   localparam int PL = 188;

   logic SYS_CLK = 1'b0;
   logic RST = 1'b1;
   always #5 SYS_CLK = ~SYS_CLK;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge SYS_CLK) cyc <= cyc + 1;

   // ---------------- main instance: N_CH=4, CH_W=3, GAP=0 ----------------
   logic [3:0]  gfp = '0, mask = '0, rd;
   logic [31:0] din = '0;
   logic [1:0]  mode = 2'd3;
   logic [2:0]  sel = '0, ach;
   logic        nen = 1'b0;
   logic [7:0]  dout;
   logic        dv, psync, npkt, serr, pdone;
   logic [3:0]  bad_mask = '0;

   ts_packet_arbiter #(.N_CH(4), .CH_W(3), .PKT_LEN(PL), .GAP(0)) dut (
      .SYS_CLK(SYS_CLK), .RST(RST), .GOT_FULL_PACKET(gfp), .DATA_IN_BUS(din),
      .RD_REQ(rd), .MODE(mode), .SEL(sel), .CH_MASK(mask), .NULL_EN(nen),
      .DATA_OUT(dout), .D_VALID_OUT(dv), .P_SYNC_OUT(psync), .ACTIVE_CH(ach),
      .NULL_PKT(npkt), .SYNC_ERR(serr), .PKT_DONE(pdone));

   // ---------------- pacing instance: N_CH=2, CH_W=1, GAP=2 ---------------
   logic [1:0]  gfp2 = '0, mask2 = '0, rd2;
   logic [15:0] din2 = '0;
   logic [1:0]  mode2 = 2'd3;
   logic [0:0]  sel2 = '0, ach2;
   logic        nen2 = 1'b0;
   logic [7:0]  dout2;
   logic        dv2, ps2, np2, se2, pd2;

   ts_packet_arbiter #(.N_CH(2), .CH_W(1), .PKT_LEN(PL), .GAP(2)) dut_gap (
      .SYS_CLK(SYS_CLK), .RST(RST), .GOT_FULL_PACKET(gfp2), .DATA_IN_BUS(din2),
      .RD_REQ(rd2), .MODE(mode2), .SEL(sel2), .CH_MASK(mask2), .NULL_EN(nen2),
      .DATA_OUT(dout2), .D_VALID_OUT(dv2), .P_SYNC_OUT(ps2), .ACTIVE_CH(ach2),
      .NULL_PKT(np2), .SYNC_ERR(se2), .PKT_DONE(pd2));

   function automatic logic [7:0] gen(input int c, input int k, input logic bad);
      if (k == 0) return bad ? 8'h00 : 8'h47;
      return 8'((c * 40 + k * 3 + 1) % 256);
   endfunction

   function automatic logic [7:0] nbyte(input int k);
      case (k)
         0: return 8'h47;
         1: return 8'h1F;
         3: return 8'h10;
         default: return 8'hFF;
      endcase
   endfunction

   // Upstream FIFO models: a pop presents the next byte on the following cycle.
   int fcnt[4];
   int fcnt2;
   always @(posedge SYS_CLK) begin
      if (RST) begin
         for (int c = 0; c < 4; c++) fcnt[c] <= 0;
         fcnt2 <= 0;
      end else begin
         for (int c = 0; c < 4; c++)
            if (rd[c]) begin
               din[8*c +: 8] <= gen(c, fcnt[c], bad_mask[c]);
               fcnt[c] <= (fcnt[c] + 1) % PL;
            end
         if (rd2[1]) begin
            din2[15:8] <= gen(1, fcnt2, 1'b0);
            fcnt2 <= (fcnt2 + 1) % PL;
         end
      end
   end

   // ---------------- scoreboard for the main instance ----------------
   typedef struct packed {
      logic [7:0] data;
      logic [2:0] ch;
      logic       sync;
      logic       done;
      logic       nul;
      logic       serr;
   } exp_t;

   exp_t q[$];
   exp_t mon_a, mon_e;
   int   vrun = 0, irun = 0;
   logic gap_chk = 1'b0;

   task automatic push_pkt(input logic [2:0] ch, input logic nul, input logic bad);
      exp_t e;
      for (int k = 0; k < PL; k++) begin
         e.data = nul ? nbyte(k) : gen(int'(ch), k, bad);
         e.ch   = ch;
         e.sync = (k == 0);
         e.done = (k == PL - 1);
         e.nul  = nul;
         e.serr = (k == 0) && !nul && bad;
         q.push_back(e);
      end
   endtask

   initial begin
      forever begin
         @(negedge SYS_CLK);
         if (RST) begin
            vrun = 0;
            irun = 0;
         end else begin
            checks++;
            if (!$onehot0(rd)) begin
               errors++;
               $display("FAIL rd_req_onehot got=%b required=at most one bit", rd);
            end
            if (dv) begin
               mon_a = '{dout, ach, psync, pdone, npkt, serr};
               checks++;
               if (q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_byte got data=%h ch=%0d required=no valid", dout, ach);
               end else begin
                  mon_e = q.pop_front();
                  if (mon_a !== mon_e) begin
                     errors++;
                     $display("FAIL byte got data=%h ch=%0d sync=%b done=%b null=%b serr=%b required data=%h ch=%0d sync=%b done=%b null=%b serr=%b",
                              mon_a.data, mon_a.ch, mon_a.sync, mon_a.done, mon_a.nul, mon_a.serr,
                              mon_e.data, mon_e.ch, mon_e.sync, mon_e.done, mon_e.nul, mon_e.serr);
                  end
               end
               if (psync) begin
                  if (gap_chk) begin
                     checks++;
                     if (irun != 1) begin
                        errors++;
                        $display("FAIL inter_pkt_idle got=%0d required=1", irun);
                     end
                  end
                  vrun = 1;
               end else begin
                  vrun++;
               end
               if (pdone) begin
                  checks++;
                  if (vrun != PL) begin
                     errors++;
                     $display("FAIL pkt_len got=%0d required=%0d", vrun, PL);
                  end
               end
               irun = 0;
            end else begin
               checks++;
               if ({psync, pdone, npkt, serr} != 4'b0) begin
                  errors++;
                  $display("FAIL strobes_idle got=%b required=0000", {psync, pdone, npkt, serr});
               end
               irun++;
               vrun = 0;
            end
         end
      end
   end

   // ---------------- scoreboard for the GAP=2 instance ----------------
   typedef struct {
      int         t;
      logic [7:0] data;
      logic       sync;
      logic       done;
   } exp2_t;

   exp2_t q2[$];
   exp2_t e2;
   int    n_rd2 = 0, rd_first2 = -1, rd_last2 = -1, idx2 = 0;

   initial begin
      forever begin
         @(negedge SYS_CLK);
         if (!RST) begin
            if (rd2 != 2'b00) begin
               checks++;
               if (rd2 != 2'b10) begin
                  errors++;
                  $display("FAIL gap_rd_chan got=%b required=10", rd2);
               end
               if (rd_first2 < 0) rd_first2 = cyc;
               else begin
                  checks++;
                  if (cyc - rd_last2 != 3) begin
                     errors++;
                     $display("FAIL gap_rd_period got=%0d required=3", cyc - rd_last2);
                  end
               end
               rd_last2 = cyc;
               n_rd2++;
               q2.push_back('{cyc + 1, gen(1, idx2, 1'b0), idx2 == 0, idx2 == PL - 1});
               idx2 = (idx2 + 1) % PL;
            end
            if (dv2) begin
               checks++;
               if (q2.size() == 0) begin
                  errors++;
                  $display("FAIL gap_unexpected_byte got=%h required=no valid", dout2);
               end else begin
                  e2 = q2.pop_front();
                  if (e2.t != cyc || e2.data !== dout2 || e2.sync !== ps2 || e2.done !== pd2 ||
                      np2 !== 1'b0 || se2 !== 1'b0 || ach2 !== 1'b1) begin
                     errors++;
                     $display("FAIL gap_byte got t=%0d data=%h sync=%b done=%b null=%b serr=%b ch=%0d required t=%0d data=%h sync=%b done=%b null=0 serr=0 ch=1",
                              cyc, dout2, ps2, pd2, np2, se2, ach2, e2.t, e2.data, e2.sync, e2.done);
                  end
               end
            end else if ({ps2, pd2, np2, se2} != 4'b0) begin
               checks++;
               errors++;
               $display("FAIL gap_strobes_idle got=%b required=0000", {ps2, pd2, np2, se2});
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   typedef struct {
      logic [1:0] mode;
      logic [2:0] sel;
      logic [3:0] mask;
      logic [3:0] gfp;
      logic       nen;
      logic       serr;
      logic [2:0] ch;
      logic       nul;
   } vec_t;

   vec_t vt[17];

   task automatic wait_sync(input string nm, input logic gap_inst);
      int n;
      for (n = 0; n < 2000; n++) begin
         @(negedge SYS_CLK);
         if (!gap_inst && dv && psync) break;
         if (gap_inst && dv2 && ps2) break;
      end
      checks++;
      if (n >= 2000) begin
         errors++;
         $display("FAIL %s timeout got=no P_SYNC_OUT required=packet start", nm);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout required=finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      //          mode  sel   mask     gfp      nen   serr  ch    null
      vt[0]  = '{2'd0, 3'd0, 4'hF,    4'hF,    1'b0, 1'b0, 3'd0, 1'b0};
      vt[1]  = '{2'd0, 3'd0, 4'hF,    4'hF,    1'b0, 1'b0, 3'd1, 1'b0};
      vt[2]  = '{2'd0, 3'd0, 4'hF,    4'hF,    1'b0, 1'b0, 3'd2, 1'b0};
      vt[3]  = '{2'd0, 3'd0, 4'hF,    4'hF,    1'b0, 1'b0, 3'd3, 1'b0};
      vt[4]  = '{2'd0, 3'd0, 4'hF,    4'hF,    1'b0, 1'b0, 3'd0, 1'b0};
      vt[5]  = '{2'd1, 3'd0, 4'hF,    4'b1010, 1'b0, 1'b0, 3'd1, 1'b0};
      vt[6]  = '{2'd1, 3'd0, 4'hF,    4'b1010, 1'b0, 1'b0, 3'd1, 1'b0};
      vt[7]  = '{2'd1, 3'd0, 4'hF,    4'b1000, 1'b0, 1'b0, 3'd3, 1'b0};
      vt[8]  = '{2'd1, 3'd0, 4'b1101, 4'b1110, 1'b0, 1'b0, 3'd2, 1'b0};
      vt[9]  = '{2'd1, 3'd0, 4'b1101, 4'b1010, 1'b0, 1'b0, 3'd3, 1'b0};
      vt[10] = '{2'd2, 3'd2, 4'hF,    4'b0001, 1'b1, 1'b0, 3'd3, 1'b1};
      vt[11] = '{2'd2, 3'd5, 4'hF,    4'b0001, 1'b1, 1'b0, 3'd3, 1'b1};
      vt[12] = '{2'd2, 3'd0, 4'hF,    4'b0001, 1'b1, 1'b0, 3'd0, 1'b0};
      vt[13] = '{2'd0, 3'd0, 4'hF,    4'hF,    1'b0, 1'b0, 3'd1, 1'b0};
      vt[14] = '{2'd1, 3'd0, 4'b0100, 4'b0100, 1'b0, 1'b1, 3'd2, 1'b0};
      vt[15] = '{2'd3, 3'd0, 4'hF,    4'hF,    1'b1, 1'b0, 3'd2, 1'b1};
      vt[16] = '{2'd0, 3'd0, 4'b1011, 4'hF,    1'b0, 1'b0, 3'd3, 1'b0};

      RST = 1'b1;
      repeat (3) @(posedge SYS_CLK);
      @(negedge SYS_CLK);
      checks++;
      if ({rd, dv, dout, psync, ach, npkt, serr, pdone} != '0) begin
         errors++;
         $display("FAIL reset_state got=%h required=0", {rd, dv, dout, psync, ach, npkt, serr, pdone});
      end
      checks++;
      if ({rd2, dv2, dout2, ps2, ach2, np2, se2, pd2} != '0) begin
         errors++;
         $display("FAIL reset_state_gap got=%h required=0", {rd2, dv2, dout2, ps2, ach2, np2, se2, pd2});
      end
      RST = 1'b0;
      repeat (5) @(negedge SYS_CLK);

      for (int v = 0; v < 17; v++) begin
         mode     = vt[v].mode;
         sel      = vt[v].sel;
         mask     = vt[v].mask;
         gfp      = vt[v].gfp;
         nen      = vt[v].nen;
         bad_mask = vt[v].serr ? (4'b0001 << vt[v].ch) : 4'b0000;
         push_pkt(vt[v].ch, vt[v].nul, vt[v].serr);
         wait_sync($sformatf("vec%0d_start", v), 1'b0);
         gap_chk = 1'b1;
      end

      // Reset 100 bytes into an RR packet (ptr=3 after the table, so ch0).
      mode = 2'd0; sel = '0; mask = 4'hF; gfp = 4'hF; nen = 1'b0; bad_mask = '0;
      push_pkt(3'd0, 1'b0, 1'b0);
      wait_sync("abort_pkt_start", 1'b0);
      repeat (100) @(negedge SYS_CLK);
      RST = 1'b1;
      @(negedge SYS_CLK);
      checks++;
      if ({rd, dv, dout, psync, ach, npkt, serr, pdone} != '0) begin
         errors++;
         $display("FAIL abort_outputs got=%h required=0", {rd, dv, dout, psync, ach, npkt, serr, pdone});
      end
      @(negedge SYS_CLK);
      q.delete();
      gap_chk = 1'b0;
      push_pkt(3'd0, 1'b0, 1'b0);
      RST = 1'b0;
      wait_sync("post_reset_start", 1'b0);
      mode = 2'd3;
      repeat (PL + 10) @(negedge SYS_CLK);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL main_drain got=%0d pending required=0", q.size());
      end

      // GAP=2 pacing on the second instance.
      mode2 = 2'd1; mask2 = 2'b11; gfp2 = 2'b10;
      wait_sync("gap_pkt_start", 1'b1);
      mode2 = 2'd3;
      repeat (3 * PL + 10) @(negedge SYS_CLK);
      checks++;
      if (n_rd2 != PL) begin
         errors++;
         $display("FAIL gap_rd_count got=%0d required=%0d", n_rd2, PL);
      end
      checks++;
      if (rd_last2 - rd_first2 + 1 != 3 * (PL - 1) + 1) begin
         errors++;
         $display("FAIL gap_read_span got=%0d required=%0d", rd_last2 - rd_first2 + 1, 3 * (PL - 1) + 1);
      end
      checks++;
      if (q2.size() != 0) begin
         errors++;
         $display("FAIL gap_drain got=%0d pending required=0", q2.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
